// File: rtl/apb_slave_bank.sv
// apb_slave_bank: three zero-wait-state APB register banks behind the AHB-to-APB bridge,
// plus global saturating transfer counters and an optional APB protocol monitor.
//
// Optional feature macro: APB_SLV_PROTO_CHK_EN
//   defined   -> protocol monitor FSM and sticky error flag are built
//   undefined -> proto_err / proto_err_code are tied to 0
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset
//   Pselx[2:0]     in   one-hot bank select (bit k selects bank k)
//   Penable        in   access phase
//   Pwrite         in   1 = write, 0 = read
//   Paddr[31:0]    in   word index = Paddr[DEPTH_LOG2+1:2]
//   Pwdata[31:0]   in   write data
//   Prdata[31:0]   out  registered read data, loaded in the read setup cycle
//   wr_count       out  completed writes over all banks, saturating
//   rd_count       out  completed reads over all banks, saturating
//   proto_err      out  sticky protocol-error flag
//   proto_err_code out  code of the first protocol error seen
module apb_slave_bank #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       Pselx,
    input  logic             Penable,
    input  logic             Pwrite,
    input  logic [31:0]      Paddr,
    input  logic [31:0]      Pwdata,
    output logic [31:0]      Prdata,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] rd_count,
    output logic             proto_err,
    output logic [1:0]       proto_err_code
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;

    logic                  sel_valid;
    logic [1:0]            bank;
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           mem_q [3][Depth];

    // Only the word-index bits of the address reach the data path.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{Paddr[31:DEPTH_LOG2+2], Paddr[1:0]};

    assign idx = Paddr[DEPTH_LOG2+1:2];

    always_comb begin
        sel_valid = 1'b1;
        bank      = 2'd0;
        case (Pselx)
            3'b001:  bank = 2'd0;
            3'b010:  bank = 2'd1;
            3'b100:  bank = 2'd2;
            default: sel_valid = 1'b0;
        endcase
    end

    // Data path: Prdata is loaded in the setup cycle so it is already stable for the
    // whole access cycle, where the bridge forwards it combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 3; b++) begin
                for (int w = 0; w < int'(Depth); w++) begin
                    mem_q[b][w] <= '0;
                end
            end
            Prdata   <= '0;
            wr_count <= '0;
            rd_count <= '0;
        end else if (sel_valid) begin
            if (!Penable && !Pwrite) begin
                Prdata <= mem_q[bank][idx];
            end
            if (Penable && Pwrite) begin
                mem_q[bank][idx] <= Pwdata;
                if (wr_count != '1) begin
                    wr_count <= wr_count + 1'b1;
                end
            end
            if (Penable && !Pwrite) begin
                if (rd_count != '1) begin
                    rd_count <= rd_count + 1'b1;
                end
            end
        end
    end

`ifdef APB_SLV_PROTO_CHK_EN
    typedef enum logic [1:0] {StIdle, StSetup, StAccess} mon_state_e;

    mon_state_e  state_q;
    logic [2:0]  sel_q;
    logic [31:0] addr_q;
    logic        write_q;
    logic        err_enable;
    logic        err_select;
    logic        err_change;
    logic [1:0]  err_code;

    always_comb begin
        err_enable = Penable && (state_q != StSetup);
        err_select = (Pselx != 3'b000) && ((Pselx & (Pselx - 3'd1)) != 3'b000);
        err_change = Penable && (state_q == StSetup) &&
                     ((Pselx != sel_q) || (Paddr != addr_q) || (Pwrite != write_q));
        // Lowest code wins when several errors coincide.
        if (err_enable) begin
            err_code = 2'd1;
        end else if (err_select) begin
            err_code = 2'd2;
        end else if (err_change) begin
            err_code = 2'd3;
        end else begin
            err_code = 2'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            sel_q          <= '0;
            addr_q         <= '0;
            write_q        <= 1'b0;
            proto_err      <= 1'b0;
            proto_err_code <= 2'd0;
        end else begin
            case (state_q)
                StSetup: begin
                    if (Penable) begin
                        state_q <= StAccess;
                    end else if (Pselx != 3'b000) begin
                        // Repeated setup: track the latest setup values.
                        sel_q   <= Pselx;
                        addr_q  <= Paddr;
                        write_q <= Pwrite;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    // StIdle and StAccess share the same exits.
                    if ((Pselx != 3'b000) && !Penable) begin
                        state_q <= StSetup;
                        sel_q   <= Pselx;
                        addr_q  <= Paddr;
                        write_q <= Pwrite;
                    end else begin
                        state_q <= StIdle;
                    end
                end
            endcase
            if (!proto_err && (err_code != 2'd0)) begin
                proto_err      <= 1'b1;
                proto_err_code <= err_code;
            end
        end
    end
`else
    assign proto_err      = 1'b0;
    assign proto_err_code = 2'd0;
`endif

endmodule
